// File: rtl/softmax_row_scheduler_pkg.sv
// Shared types for the softmax row scheduler: FSM states, default widths, row command record.
package softmax_sched_pkg;

  localparam int DEF_AW      = 32;
  localparam int DEF_TOK_W   = 12;
  localparam int DEF_HEAD_W  = 8;
  localparam int DEF_MAX_OUT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [DEF_AW-1:0]     in_addr;
    logic [DEF_AW-1:0]     out_addr;
    logic [DEF_TOK_W-1:0]  len;
    logic [DEF_HEAD_W-1:0] head;
    logic [DEF_TOK_W-1:0]  idx;
    logic                  last;
  } row_cmd_t;

endpackage

// File: rtl/softmax_row_scheduler_if.sv
// Row command channel between the scheduler (master) and the softmax row engine (slave).
interface softmax_row_scheduler_if
  import softmax_sched_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int TOK_W  = DEF_TOK_W,
  parameter int HEAD_W = DEF_HEAD_W
) ();

  logic              valid;
  logic              ready;
  logic [AW-1:0]     in_addr;
  logic [AW-1:0]     out_addr;
  logic [TOK_W-1:0]  len;
  logic [HEAD_W-1:0] head;
  logic [TOK_W-1:0]  idx;
  logic              last;
  logic              done;

  modport master (
    output valid, in_addr, out_addr, len, head, idx, last,
    input  ready, done
  );

  modport slave (
    input  valid, in_addr, out_addr, len, head, idx, last,
    output ready, done
  );

endinterface

// File: rtl/softmax_row_scheduler_addr_walker.sv
// Head/row position and input/output address accumulators; advances one row per step, no multipliers.
module softmax_addr_walker #(
  parameter int AW     = 32,
  parameter int TOK_W  = 12,
  parameter int HEAD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [AW-1:0]     in_base,
  input  logic [AW-1:0]     in_head_stride,
  input  logic [AW-1:0]     in_line_stride,
  input  logic [AW-1:0]     out_base,
  input  logic [AW-1:0]     out_head_stride,
  input  logic [AW-1:0]     out_line_stride,
  input  logic [TOK_W-1:0]  rows,
  input  logic [HEAD_W-1:0] heads,
  output logic [AW-1:0]     in_addr,
  output logic [AW-1:0]     out_addr,
  output logic [TOK_W-1:0]  idx,
  output logic [TOK_W-1:0]  idx_next,
  output logic [HEAD_W-1:0] head,
  output logic              last
);

  logic [AW-1:0]     in_hs, in_ls, out_hs, out_ls;
  logic [AW-1:0]     in_hacc, out_hacc;
  logic [TOK_W-1:0]  rows_m1;
  logic [HEAD_W-1:0] heads_m1;
  logic              row_end;

  assign row_end  = (idx == rows_m1);
  assign last     = row_end && (head == heads_m1);
  assign idx_next = row_end ? '0 : idx + TOK_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_hs    <= '0;
      in_ls    <= '0;
      out_hs   <= '0;
      out_ls   <= '0;
      in_hacc  <= '0;
      out_hacc <= '0;
      rows_m1  <= '0;
      heads_m1 <= '0;
      in_addr  <= '0;
      out_addr <= '0;
      idx      <= '0;
      head     <= '0;
    end else if (load) begin
      in_hs    <= in_head_stride;
      in_ls    <= in_line_stride;
      out_hs   <= out_head_stride;
      out_ls   <= out_line_stride;
      in_hacc  <= in_base;
      out_hacc <= out_base;
      rows_m1  <= rows - TOK_W'(1);
      heads_m1 <= heads - HEAD_W'(1);
      in_addr  <= in_base;
      out_addr <= out_base;
      idx      <= '0;
      head     <= '0;
    end else if (step) begin
      idx <= idx_next;
      // New head restarts from the head accumulator, not from the running row address.
      if (row_end) begin
        head     <= head + HEAD_W'(1);
        in_hacc  <= in_hacc + in_hs;
        out_hacc <= out_hacc + out_hs;
        in_addr  <= in_hacc + in_hs;
        out_addr <= out_hacc + out_hs;
      end else begin
        in_addr  <= in_addr + in_ls;
        out_addr <= out_addr + out_ls;
      end
    end
  end

endmodule

// File: rtl/softmax_row_scheduler.sv
// Walks heads x rows issuing softmax row commands; first command 1 cycle after start, at most
// MAX_OUTSTANDING unacknowledged rows. Optional perf counters under SOFTMAX_SCHED_PERF_EN.
module softmax_row_scheduler
  import softmax_sched_pkg::*;
#(
  parameter int AW              = DEF_AW,
  parameter int TOK_W           = DEF_TOK_W,
  parameter int HEAD_W          = DEF_HEAD_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [AW-1:0]     cfg_in_base,
  input  logic [AW-1:0]     cfg_in_head_stride,
  input  logic [AW-1:0]     cfg_in_line_stride,
  input  logic [AW-1:0]     cfg_out_base,
  input  logic [AW-1:0]     cfg_out_head_stride,
  input  logic [AW-1:0]     cfg_out_line_stride,
  input  logic [TOK_W-1:0]  cfg_rows,
  input  logic [TOK_W-1:0]  cfg_width,
  input  logic [HEAD_W-1:0] cfg_heads,
  input  logic              cfg_mask_en,
  input  logic [TOK_W-1:0]  cfg_kv_pos,
  output logic              busy,
  output logic              done,
  softmax_row_scheduler_if.master row,
  output logic              err_underflow
`ifdef SOFTMAX_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  sched_state_e      state, state_nxt;
  logic [OW-1:0]     outstanding, outstanding_nxt;
  logic              underflow;
  logic              mask_sh;
  logic [TOK_W-1:0]  kv_sh, width_sh, len_q;
  logic              start_acc, empty_job, row_valid, xfer, step;
  logic [AW-1:0]     w_in, w_out;
  logic [TOK_W-1:0]  w_idx, w_idx_nxt;
  logic [HEAD_W-1:0] w_head;
  logic              w_last;

  function automatic logic [TOK_W-1:0] len_of(input logic [TOK_W-1:0] idx,
                                              input logic mask,
                                              input logic [TOK_W-1:0] kv,
                                              input logic [TOK_W-1:0] width);
    logic [TOK_W+1:0] reach;
    reach = {2'b00, idx} + {2'b00, kv} + (TOK_W+2)'(1);
    if (!mask || reach >= {2'b00, width}) return width;
    return reach[TOK_W-1:0];
  endfunction

  assign start_acc = cfg_start && (state == IDLE);
  assign empty_job = (cfg_rows == '0) || (cfg_heads == '0);
  assign xfer      = row_valid && row.ready;
  assign step      = xfer && !w_last;

  softmax_addr_walker #(
    .AW     (AW),
    .TOK_W  (TOK_W),
    .HEAD_W (HEAD_W)
  ) u_walker (
    .clk             (clk),
    .rst_n           (rst_n),
    .load            (start_acc),
    .step            (step),
    .in_base         (cfg_in_base),
    .in_head_stride  (cfg_in_head_stride),
    .in_line_stride  (cfg_in_line_stride),
    .out_base        (cfg_out_base),
    .out_head_stride (cfg_out_head_stride),
    .out_line_stride (cfg_out_line_stride),
    .rows            (cfg_rows),
    .heads           (cfg_heads),
    .in_addr         (w_in),
    .out_addr        (w_out),
    .idx             (w_idx),
    .idx_next        (w_idx_nxt),
    .head            (w_head),
    .last            (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_sh  <= 1'b0;
      kv_sh    <= '0;
      width_sh <= '0;
      len_q    <= '0;
    end else if (start_acc) begin
      mask_sh  <= cfg_mask_en;
      kv_sh    <= cfg_kv_pos;
      width_sh <= cfg_width;
      len_q    <= len_of('0, cfg_mask_en, cfg_kv_pos, cfg_width);
    end else if (step) begin
      len_q    <= len_of(w_idx_nxt, mask_sh, kv_sh, width_sh);
    end
  end

  always_comb begin
    outstanding_nxt = outstanding;
    underflow       = 1'b0;
    if (xfer && !row.done) begin
      outstanding_nxt = outstanding + OW'(1);
    end else if (!xfer && row.done) begin
      if (outstanding == '0) underflow = 1'b1;
      else                   outstanding_nxt = outstanding - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (underflow)      err_underflow <= 1'b1;
      else if (start_acc) err_underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // Empty jobs pass through DRAIN so busy is still seen for one cycle.
      IDLE:    if (start_acc) state_nxt = empty_job ? DRAIN : ISSUE;
      ISSUE:   if (xfer && w_last) state_nxt = DRAIN;
      DRAIN:   if (outstanding_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ISSUE) || (state == DRAIN);
    done      = (state == DONE);
    row_valid = (state == ISSUE) && (outstanding < OUT_MAX);
  end

  assign row.valid    = row_valid;
  assign row.in_addr  = w_in;
  assign row.out_addr = w_out;
  assign row.len      = len_q;
  assign row.head     = w_head;
  assign row.idx      = w_idx;
  assign row.last     = row_valid && w_last;

`ifdef SOFTMAX_SCHED_PERF_EN
  logic stall;
  assign stall = (row_valid && !row.ready) || ((state == ISSUE) && (outstanding == OUT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (start_acc) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)   perf_busy_cycles  <= perf_busy_cycles + 32'd1;
      if (stall && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed bench for softmax_row_scheduler: captures every row transfer and compares against a row model.
module tb_softmax_row_scheduler;
  import softmax_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_in_base, cfg_in_head_stride, cfg_in_line_stride;
  logic [31:0] cfg_out_base, cfg_out_head_stride, cfg_out_line_stride;
  logic [11:0] cfg_rows, cfg_width, cfg_kv_pos;
  logic [7:0]  cfg_heads;
  logic        cfg_mask_en;
  logic        busy, done, err_underflow;
  logic [31:0] perf_busy, perf_stall;

  logic ready_man, ready_rnd, rand_ready, man_done, auto_done, auto_ack;

  always #5 clk = ~clk;

  softmax_row_scheduler_if ifc ();
  assign ifc.ready = rand_ready ? ready_rnd : ready_man;
  assign ifc.done  = man_done | auto_done;

  softmax_row_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_start           (cfg_start),
    .cfg_in_base         (cfg_in_base),
    .cfg_in_head_stride  (cfg_in_head_stride),
    .cfg_in_line_stride  (cfg_in_line_stride),
    .cfg_out_base        (cfg_out_base),
    .cfg_out_head_stride (cfg_out_head_stride),
    .cfg_out_line_stride (cfg_out_line_stride),
    .cfg_rows            (cfg_rows),
    .cfg_width           (cfg_width),
    .cfg_heads           (cfg_heads),
    .cfg_mask_en         (cfg_mask_en),
    .cfg_kv_pos          (cfg_kv_pos),
    .busy                (busy),
    .done                (done),
    .row                 (ifc.master),
    .err_underflow       (err_underflow)
`ifdef SOFTMAX_SCHED_PERF_EN
    ,
    .perf_busy_cycles    (perf_busy),
    .perf_stall_cycles   (perf_stall)
`endif
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int stab_bad = 0;
  row_cmd_t cap_q[$];

  // job description used both to drive cfg_* and by the model
  logic [31:0] j_in_base, j_in_head, j_in_line, j_out_base, j_out_head, j_out_line;
  int j_rows, j_width, j_heads, j_kv;
  logic j_mask;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pclk();
    @(posedge clk);
    #1;
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  function automatic row_cmd_t model(input int h, input int r);
    row_cmd_t c;
    int l;
    l = j_mask ? (r + 1 + j_kv) : j_width;
    if (l > j_width) l = j_width;
    c.in_addr  = 32'(j_in_base + 32'(h) * j_in_head + 32'(r) * j_in_line);
    c.out_addr = 32'(j_out_base + 32'(h) * j_out_head + 32'(r) * j_out_line);
    c.len      = 12'(l);
    c.head     = 8'(h);
    c.idx      = 12'(r);
    c.last     = (h == j_heads - 1) && (r == j_rows - 1);
    return c;
  endfunction

  // Monitor: logs transfers, counts done pulses, checks stall stability, returns row_done 3 cycles later.
  initial begin
    logic [2:0] pipe;
    logic prev_stall;
    row_cmd_t cur, prev;
    pipe = '0;
    prev_stall = 1'b0;
    prev = '0;
    auto_done = 1'b0;
    forever begin
      @(negedge clk);
      cur.in_addr  = ifc.in_addr;
      cur.out_addr = ifc.out_addr;
      cur.len      = ifc.len;
      cur.head     = ifc.head;
      cur.idx      = ifc.idx;
      cur.last     = ifc.last;
      if (!rst_n) begin
        pipe = '0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !(ifc.valid && cur == prev)) stab_bad++;
        prev_stall = ifc.valid && !ifc.ready;
        prev = cur;
        if (ifc.valid && ifc.ready) cap_q.push_back(cur);
        if (done) done_cnt++;
        pipe = {pipe[1:0], ifc.valid && ifc.ready};
      end
      @(posedge clk);
      #1;
      auto_done = auto_ack && pipe[2] && rst_n;
    end
  end

  initial begin
    ready_rnd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ready_rnd = 1'($urandom_range(0, 1));
    end
  end

  task automatic start_job();
    pclk();
    cfg_in_base = j_in_base;   cfg_in_head_stride = j_in_head;   cfg_in_line_stride = j_in_line;
    cfg_out_base = j_out_base; cfg_out_head_stride = j_out_head; cfg_out_line_stride = j_out_line;
    cfg_rows = 12'(j_rows); cfg_width = 12'(j_width); cfg_heads = 8'(j_heads);
    cfg_mask_en = j_mask; cfg_kv_pos = 12'(j_kv);
    cfg_start = 1'b1;
    pclk();
    cfg_start = 1'b0;
    cfg_in_base = $urandom(); cfg_in_line_stride = $urandom(); cfg_out_head_stride = $urandom();
    cfg_rows = 12'($urandom()); cfg_heads = 8'($urandom()); cfg_width = 12'($urandom());
    cfg_mask_en = ~j_mask; cfg_kv_pos = 12'($urandom());
  endtask

  task automatic set_job(input int rows, input int width, input int heads, input logic mask, input int kv,
                         input logic [31:0] ib, input logic [31:0] ih, input logic [31:0] il,
                         input logic [31:0] ob, input logic [31:0] oh, input logic [31:0] ol);
    j_rows = rows; j_width = width; j_heads = heads; j_mask = mask; j_kv = kv;
    j_in_base = ib; j_in_head = ih; j_in_line = il;
    j_out_base = ob; j_out_head = oh; j_out_line = ol;
    cap_q.delete();
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      nclk();
      n++;
    end
    chk({tag, " done seen"}, 128'(done_cnt != d0), 128'(1));
  endtask

  task automatic verify(input string tag, input int d0);
    int n;
    repeat (4) nclk();
    chk({tag, " done once"}, 128'(done_cnt - d0), 128'(1));
    chk({tag, " cmd count"}, 128'(cap_q.size()), 128'(j_rows * j_heads));
    chk({tag, " busy idle"}, 128'(busy), 128'(0));
    chk({tag, " no err"}, 128'(err_underflow), 128'(0));
    n = 0;
    for (int h = 0; h < j_heads; h++) begin
      for (int r = 0; r < j_rows; r++) begin
        if (n < cap_q.size()) chk($sformatf("%s h%0d r%0d", tag, h, r), 128'(cap_q[n]), 128'(model(h, r)));
        n++;
      end
    end
  endtask

  task automatic pulse_done();
    pclk();
    man_done = 1'b1;
    pclk();
    man_done = 1'b0;
  endtask

  initial begin
    int d0, n;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_in_base = '0; cfg_in_head_stride = '0; cfg_in_line_stride = '0;
    cfg_out_base = '0; cfg_out_head_stride = '0; cfg_out_line_stride = '0;
    cfg_rows = '0; cfg_width = '0; cfg_heads = '0; cfg_mask_en = 1'b0; cfg_kv_pos = '0;
    ready_man = 1'b0; rand_ready = 1'b0; man_done = 1'b0; auto_ack = 1'b0;

    nclk();
    chk("rst ctl", 128'({busy, done, ifc.valid, ifc.last, err_underflow}), 128'(0));
    chk("rst addr", 128'({ifc.in_addr, ifc.out_addr}), 128'(0));
    chk("rst len/head/idx", 128'({ifc.len, ifc.head, ifc.idx}), 128'(0));
    pclk();
    rst_n = 1'b1;

    // causal job, continuous ready, acks 3 cycles after each transfer
    set_job(39, 39, 2, 1'b1, 0, 32'h0, 32'h1000, 32'd64, 32'h0800_0000, 32'h1000, 32'd64);
    ready_man = 1'b1; auto_ack = 1'b1;
    d0 = done_cnt;
    start_job();
    nclk();
    chk("causal busy", 128'(busy), 128'(1));
    wait_done("causal", d0);
    verify("causal", d0);
    if (cap_q.size() == 78) begin
      chk("h0r0 len", 128'(cap_q[0].len), 128'(1));
      chk("h0r38 len", 128'(cap_q[38].len), 128'(39));
      chk("h1r0 in", 128'(cap_q[39].in_addr), 128'(32'h1000));
      chk("h1r0 out", 128'(cap_q[39].out_addr), 128'(32'h0800_1000));
      chk("h1r0 len", 128'(cap_q[39].len), 128'(1));
      chk("last flag", 128'({cap_q[76].last, cap_q[77].last}), 128'(2'b01));
    end

    // KV-cache single row per head, mask off
    set_job(1, 39, 2, 1'b0, 7, 32'h2000_0040, 32'h400, 32'h80, 32'h100, 32'h800, 32'h20);
    d0 = done_cnt;
    start_job();
    wait_done("kv", d0);
    verify("kv", d0);
    if (cap_q.size() == 2) begin
      chk("kv h1 in", 128'(cap_q[1].in_addr), 128'(32'h2000_0440));
      chk("kv h1 out", 128'(cap_q[1].out_addr), 128'(32'h900));
      chk("kv len", 128'(cap_q[1].len), 128'(39));
    end

    // backpressure: random ready, no acks -> window of 4
    auto_ack = 1'b0; rand_ready = 1'b1;
    set_job(10, 20, 1, 1'b1, 2, 32'h40, 32'h0, 32'h100, 32'h9000, 32'h0, 32'h40);
    d0 = done_cnt;
    stab_bad = 0;
    start_job();
    n = 0;
    while (cap_q.size() < 4 && n < 500) begin
      nclk();
      n++;
    end
    repeat (20) nclk();
    chk("bp window", 128'(cap_q.size()), 128'(4));
    chk("bp valid low", 128'(ifc.valid), 128'(0));
    chk("bp stable", 128'(stab_bad), 128'(0));
    rand_ready = 1'b0; ready_man = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pulse_done();
      repeat (4) nclk();
      chk($sformatf("bp credit %0d", k), 128'(cap_q.size()), 128'(5 + k));
    end
    chk("bp valid low 2", 128'(ifc.valid), 128'(0));
    repeat (4) begin
      pulse_done();
      pclk();
    end
    wait_done("bp", d0);
    verify("bp", d0);

    // empty job: done pulse two cycles after start, no commands
    set_job(0, 10, 3, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    d0 = done_cnt;
    start_job();
    nclk();
    chk("zero busy", 128'({busy, done}), 128'(2'b10));
    nclk();
    chk("zero done", 128'({busy, done}), 128'(2'b01));
    nclk();
    chk("zero done gone", 128'(done), 128'(0));
    chk("zero cmds", 128'(cap_q.size()), 128'(0));

    // mask saturation
    auto_ack = 1'b1;
    set_job(5, 39, 1, 1'b1, 4090, 32'h100, 32'h0, 32'h40, 32'h200, 32'h0, 32'h40);
    d0 = done_cnt;
    start_job();
    wait_done("sat", d0);
    verify("sat", d0);

    // simultaneous transfer and row_done keeps the count
    auto_ack = 1'b0; ready_man = 1'b0;
    set_job(8, 8, 1, 1'b0, 0, 32'h0, 32'h0, 32'h10, 32'h0, 32'h0, 32'h10);
    d0 = done_cnt;
    start_job();
    ready_man = 1'b1;
    repeat (3) pclk();
    ready_man = 1'b0;
    pclk();
    ready_man = 1'b1; man_done = 1'b1;
    pclk();
    man_done = 1'b0;
    repeat (6) nclk();
    chk("simul count", 128'(cap_q.size()), 128'(5));
    chk("simul valid low", 128'(ifc.valid), 128'(0));
    repeat (7) begin
      pulse_done();
      repeat (2) pclk();
    end
    wait_done("simul", d0);
    verify("simul", d0);

    // spurious row_done in IDLE, cleared by next start
    chk("err idle", 128'(err_underflow), 128'(0));
    pulse_done();
    nclk();
    chk("err set", 128'(err_underflow), 128'(1));
    auto_ack = 1'b1;
    set_job(2, 5, 1, 1'b1, 0, 32'h0, 32'h0, 32'h20, 32'h0, 32'h0, 32'h20);
    d0 = done_cnt;
    start_job();
    nclk();
    chk("err cleared", 128'(err_underflow), 128'(0));
    wait_done("errjob", d0);
    verify("errjob", d0);

    // asynchronous reset mid-job, then a clean job
    set_job(20, 30, 2, 1'b1, 3, 32'h0, 32'h4000, 32'h80, 32'h1_0000, 32'h4000, 32'h80);
    start_job();
    repeat (10) pclk();
    #2;
    rst_n = 1'b0;
    auto_ack = 1'b0;
    #1;
    chk("mid rst ctl", 128'({busy, done, ifc.valid, ifc.last, err_underflow}), 128'(0));
    chk("mid rst addr", 128'({ifc.in_addr, ifc.out_addr}), 128'(0));
    chk("mid rst len/head/idx", 128'({ifc.len, ifc.head, ifc.idx}), 128'(0));
    repeat (2) nclk();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    auto_ack = 1'b1;
    set_job(3, 6, 3, 1'b1, 1, 32'h500, 32'h300, 32'h40, 32'h7000, 32'h200, 32'h20);
    d0 = done_cnt;
    start_job();
    wait_done("post rst", d0);
    verify("post rst", d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
